memory_responder: RTL and testbench
===================================

Name: memory_responder

Overview:
- Target end of the cpu's memory_valid/memory_ready bus: the responder that the cpu core's memory port talks to in simulation and formal harnesses.
- Holds a word-organised SRAM with byte-write strobes.
- Inserts configurable wait states, separately for instruction fetches and data accesses.
- Returns memory_ready for exactly one cycle per request, and flags out-of-range accesses.

Parameters:
- ADDR_WIDTH, 12: log2 of array depth in 32-bit words (default 4096 words = 16 KiB).
- BASE_ADDR, 32'h0000_0000: byte base address of the array; must be aligned to 2^(ADDR_WIDTH+2).
- INSTR_WAIT, 0: extra wait cycles for requests with memory_instr=1, range 0..255.
- DATA_WAIT, 1: extra wait cycles for requests with memory_instr=0, range 0..255.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- memory_valid  input  1  request present; held by the initiator until memory_ready.
- memory_instr  input  1  1 = instruction fetch, 0 = data access.
- memory_addr  input  32  byte address; bits [1:0] are ignored (word access).
- memory_wdata  input  32  write data.
- memory_wstrb  input  4  byte enables; 4'b0000 = read.
- memory_rdata  output  32  read data, valid only while memory_ready=1.
- memory_ready  output  1  one-cycle completion pulse.
- memory_error  output  1  pulses with memory_ready when the address was out of range.

Behaviour:
- Reset (async, immediate):
  - memory_ready=0, memory_error=0, memory_rdata=0.
  - State IDLE, wait counter 0.
  - Array contents are not cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On memory_valid=1 at a rising edge, latch addr, wdata, wstrb and instr.
  - Load the counter with INSTR_WAIT or DATA_WAIT according to instr.
  - Go to WAIT if the count is nonzero, else go to RESP.
- WAIT: decrement the counter each cycle; on the edge where the counter is 1, go to RESP.
- Edge entering RESP: array access happens on this edge.
  - In range (addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]):
    - Index = addr[ADDR_WIDTH+1:2].
    - Each byte i with wstrb[i]=1 is written; other bytes are unchanged.
    - memory_rdata = pre-write word if wstrb==0, else 0.
  - Out of range: no write, memory_rdata=0, memory_error=1.
- RESP:
  - memory_ready=1 for exactly this one cycle.
  - Next edge: return to IDLE, ready, error and rdata clear to 0.
- Latency: ready is asserted 1+WAIT cycles after the first edge sampling valid.
  - With WAIT=0, ready appears in the cycle after the request edge.
- Back-to-back: in the cycle after RESP (IDLE), a valid that is still or newly asserted is accepted as a new request.
  - Max throughput: one request every 2+WAIT cycles.
- Request inputs are ignored outside IDLE.
  - A valid deasserted mid-WAIT (a protocol violation) still completes using the latched copy.
- instr=1 with wstrb≠0: treated as a write (no special case).
- Reset during WAIT/RESP: the pending request is abandoned with no write.
  - A write whose RESP-entry edge already occurred remains committed.
- Outputs are registered; no combinational path from inputs to memory_ready or memory_rdata.

Decomposition:
- Package memory_responder_pkg holds:
  - the state enum (IDLE/WAIT/RESP);
  - WAIT_COUNT_WIDTH=8;
  - the request struct (addr, wdata, wstrb, instr).
- Sub-module memory_array: single-port synchronous RAM with 4-bit byte-enable write and read-before-write output, parameterised by ADDR_WIDTH.
- The responder FSM, counter and range check stay in memory_responder.

Test Plan:
- Write, then read (INSTR_WAIT=0, DATA_WAIT=1):
  - Stimulus: data write addr=0x10, wdata=0xDEADBEEF, wstrb=4'hF; then read 0x10 with wstrb=0.
  - Response: each request gets ready exactly 2 cycles after the request edge; read rdata=0xDEADBEEF, error=0.
- Byte strobes:
  - Stimulus: write 0x11223344 to 0x20; write wdata=0xAABBCCDD with wstrb=4'b0101; then read 0x20.
  - Response: read returns 0x11BB33DD.
- Fetch latency:
  - Stimulus: instr=1 read of 0x10 with INSTR_WAIT=0.
  - Response: ready exactly 1 cycle after the request edge, rdata=0xDEADBEEF; ready is high for one cycle only.
- Out of range (BASE_ADDR=0, ADDR_WIDTH=12):
  - Stimulus: write 0x5A5A5A5A to 0x0000_4010 (aliases index 4), then read 0x10.
  - Response: error=1 and rdata=0 on the out-of-range response; the following read still returns 0xDEADBEEF.
- Back-to-back and mid-operation reset:
  - Stimulus: hold valid continuously across 3 reads.
    - Response: ready pulses with one idle cycle between them.
  - Stimulus: assert rst during WAIT of a write to 0x30 (previous value 0).
    - Response: ready drops immediately, no ready pulse is produced, and a later read of 0x30 returns 0.

Source files
------------

// File: rtl/memory_responder_pkg.sv
// Shared types and helpers for the memory responder: FSM states, the latched
// request record and the address range check.
package memory_responder_pkg;

    localparam int WAIT_COUNT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
    } request_t;

    // Address hits the array when every bit above the word index matches the base.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int          addr_width);
        return (addr >> (addr_width + 2)) == (base >> (addr_width + 2));
    endfunction

endpackage

// File: rtl/memory_array.sv
// Word-organised single-port synchronous RAM with per-byte write enables.
// The read port returns the word as it was before any write on the same edge.
module memory_array #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] index,
    input  logic [3:0]            wstrb,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[index];
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[index][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/memory_responder.sv
// Target side of the cpu memory_valid/memory_ready bus: SRAM with byte strobes,
// per-class wait states, one-cycle ready pulse and out-of-range error flag.
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          INSTR_WAIT = 0,
    parameter int          DATA_WAIT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memory_valid,
    input  logic        memory_instr,
    input  logic [31:0] memory_addr,
    input  logic [31:0] memory_wdata,
    input  logic [3:0]  memory_wstrb,
    output logic [31:0] memory_rdata,
    output logic        memory_ready,
    output logic        memory_error
);

    localparam logic [WAIT_COUNT_WIDTH-1:0] INSTR_COUNT = WAIT_COUNT_WIDTH'(INSTR_WAIT);
    localparam logic [WAIT_COUNT_WIDTH-1:0] DATA_COUNT  = WAIT_COUNT_WIDTH'(DATA_WAIT);

    state_t                      state;
    logic [WAIT_COUNT_WIDTH-1:0] count;
    logic [WAIT_COUNT_WIDTH-1:0] load_count;
    request_t                    req_q;
    request_t                    cur;
    logic                        in_range;
    logic                        enter_resp;
    logic                        access;
    logic                        rdata_en;
    logic [31:0]                 array_rdata;

    // In IDLE a zero-wait request goes straight to RESP, so the array must see
    // the live bus; otherwise it works from the latched copy.
    always_comb begin
        cur = req_q;
        if (state == IDLE) begin
            cur = '{addr:  memory_addr,
                    wdata: memory_wdata,
                    wstrb: memory_wstrb,
                    instr: memory_instr};
        end
    end

    assign load_count = cur.instr ? INSTR_COUNT : DATA_COUNT;
    assign in_range   = addr_in_range(cur.addr, BASE_ADDR, ADDR_WIDTH);
    assign enter_resp = ((state == IDLE) && memory_valid && (load_count == '0)) ||
                        ((state == WAIT) && (count == WAIT_COUNT_WIDTH'(1)));
    // Held off during reset so an abandoned request can never commit a write.
    assign access     = enter_resp && in_range && !rst;

    memory_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .en    (access),
        .index (cur.addr[ADDR_WIDTH+1:2]),
        .wstrb (cur.wstrb),
        .wdata (cur.wdata),
        .rdata (array_rdata)
    );

    always_ff @(posedge clk) begin
        if ((state == IDLE) && memory_valid) begin
            req_q <= cur;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            memory_ready <= 1'b0;
            memory_error <= 1'b0;
            rdata_en     <= 1'b0;
        end else begin
            memory_ready <= 1'b0;
            memory_error <= 1'b0;
            rdata_en     <= 1'b0;
            case (state)
                IDLE: begin
                    if (memory_valid) begin
                        count <= load_count;
                        state <= (load_count == '0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    count <= count - WAIT_COUNT_WIDTH'(1);
                    if (count == WAIT_COUNT_WIDTH'(1)) begin
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (enter_resp) begin
                memory_ready <= 1'b1;
                memory_error <= !in_range;
                rdata_en     <= in_range && (cur.wstrb == 4'b0000);
            end
        end
    end

    // Read data is only exposed for in-range reads; writes and errors return zero.
    assign memory_rdata = rdata_en ? array_rdata : 32'h0000_0000;

endmodule

// File: tb/tb_memory_responder.sv
// Randomised bench for memory_responder against a word-array reference model.
module tb_memory_responder;

    localparam int          AW     = 12;
    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam int          IW     = 0;
    localparam int          DW     = 1;
    localparam int          REGION = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;
    logic        error;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_mem [REGION];
    logic [31:0] got_rd;
    logic [31:0] b2b_addr [3];
    int          cyc;
    bit          ok;
    int          pulses;

    always #5 clk = ~clk;

    memory_responder #(
        .ADDR_WIDTH (AW),
        .BASE_ADDR  (BASE),
        .INSTR_WAIT (IW),
        .DATA_WAIT  (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .memory_valid (valid),
        .memory_instr (instr),
        .memory_addr  (addr),
        .memory_wdata (wdata),
        .memory_wstrb (wstrb),
        .memory_rdata (rdata),
        .memory_ready (ready),
        .memory_error (error)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit ref_in_range(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < (32'd4 << AW));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] ws);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Counts rising edges until ready is seen at a falling edge; bounded.
    task automatic wait_ready(output int n, output bit seen);
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (ready) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // One complete transaction, started and finished at a falling edge.
    task automatic xact(input logic i_instr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input string tag, output logic [31:0] got);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          idx;
        int          n;
        bit          seen;
        exp_rd  = 32'h0;
        exp_err = 1'b0;
        if (ref_in_range(a)) begin
            idx = int'((a - BASE) >> 2);
            if (ws == 4'b0000) exp_rd = ref_mem[idx];
            else ref_mem[idx] = merge(ref_mem[idx], wd, ws);
        end else begin
            exp_err = 1'b1;
        end
        valid = 1'b1;
        instr = i_instr;
        addr  = a;
        wdata = wd;
        wstrb = ws;
        wait_ready(n, seen);
        valid = 1'b0;
        addr  = $urandom;
        wdata = $urandom;
        wstrb = 4'($urandom_range(0, 15));
        got   = rdata;
        if (!seen) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({tag, "_lat"}, 32'(n), 32'(1 + (i_instr ? IW : DW)));
        chk({tag, "_rdata"}, rdata, exp_rd);
        chk({tag, "_err"}, 32'(error), 32'(exp_err));
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_onepulse"}, 32'(ready), 32'd0);
        chk({tag, "_errclr"}, 32'(error), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        instr = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        wstrb = 4'h0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst = 1'b0;

        for (int w = 0; w < REGION; w++) xact(1'b0, 32'(w * 4), $urandom, 4'hF, "init", got_rd);

        xact(1'b0, 32'h10, 32'hDEADBEEF, 4'hF, "wr10", got_rd);
        xact(1'b0, 32'h10, 32'h0, 4'h0, "rd10", got_rd);
        chk("rd10_const", got_rd, 32'hDEADBEEF);

        xact(1'b0, 32'h20, 32'h11223344, 4'hF, "wr20", got_rd);
        xact(1'b0, 32'h20, 32'hAABBCCDD, 4'b0101, "strb20", got_rd);
        xact(1'b0, 32'h20, 32'h0, 4'h0, "rd20", got_rd);
        chk("strobe_const", got_rd, 32'h11BB33DD);

        xact(1'b1, 32'h10, 32'h0, 4'h0, "fetch10", got_rd);
        chk("fetch_const", got_rd, 32'hDEADBEEF);

        xact(1'b0, 32'h0000_4010, 32'h5A5A5A5A, 4'hF, "oor_wr", got_rd);
        xact(1'b0, 32'h10, 32'h0, 4'h0, "oor_after", got_rd);
        chk("oor_alias_const", got_rd, 32'hDEADBEEF);

        // Back-to-back fetches with valid held high throughout.
        b2b_addr[0] = 32'h10;
        b2b_addr[1] = 32'h20;
        b2b_addr[2] = 32'h30;
        valid = 1'b1;
        instr = 1'b1;
        wstrb = 4'h0;
        addr  = b2b_addr[0];
        for (int k = 0; k < 3; k++) begin
            wait_ready(cyc, ok);
            chk("b2b_seen", 32'(ok), 32'd1);
            chk("b2b_gap", 32'(cyc), (k == 0) ? 32'd1 : 32'd2);
            chk("b2b_rdata", rdata, ref_mem[b2b_addr[k] >> 2]);
            if (k < 2) addr = b2b_addr[k+1];
        end
        valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_end", 32'(ready), 32'd0);

        // Reset while a write waits: the write must be dropped.
        xact(1'b0, 32'h30, 32'h0, 4'hF, "clr30", got_rd);
        valid = 1'b1;
        instr = 1'b0;
        addr  = 32'h30;
        wdata = 32'hCAFEF00D;
        wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        chk("rstw_waiting", 32'(ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("rstw_ready", 32'(ready), 32'd0);
        valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            if (ready) pulses++;
        end
        chk("rstw_nopulse", 32'(pulses), 32'd0);
        xact(1'b0, 32'h30, 32'h0, 4'h0, "rd30", got_rd);
        chk("rd30_const", got_rd, 32'h0);

        // Reset while ready is high: the committed write stays, ready drops at once.
        valid = 1'b1;
        instr = 1'b0;
        addr  = 32'h34;
        wdata = 32'h12345678;
        wstrb = 4'hF;
        wait_ready(cyc, ok);
        chk("rstr_seen", 32'(ok), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstr_ready", 32'(ready), 32'd0);
        chk("rstr_rdata", rdata, 32'd0);
        valid = 1'b0;
        ref_mem[13] = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        xact(1'b0, 32'h34, 32'h0, 4'h0, "rd34", got_rd);
        chk("rd34_const", got_rd, 32'h12345678);

        for (int r = 0; r < 200; r++) begin
            logic [31:0] a;
            logic [3:0]  ws;
            a = 32'($urandom_range(0, REGION - 1) * 4) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = a | (32'($urandom_range(1, 255)) << (AW + 2));
            ws = ($urandom_range(0, 4) < 2) ? 4'h0 : 4'($urandom_range(1, 15));
            xact(1'($urandom_range(0, 1)), a, $urandom, ws, "rand", got_rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
